// File: rtl/counter_cascade_nd.sv
// Cascaded multi-digit up/down counter: NDIG stages of DW bits, each modulo MODV,
// with parallel load, terminal count, optional saturation and sticky overflow.
module counter_cascade_nd #(
  parameter int NDIG = 2,
  parameter int DW   = 4,
  parameter int MODV = 16,
  parameter int SAT  = 0
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 l,
  input  logic                 s_s,
  input  logic                 up,
  input  logic [NDIG*DW-1:0]   d,
  output logic [NDIG*DW-1:0]   c,
  output logic [NDIG-1:0]      cr,
  output logic                 tc,
  output logic                 ovf
);

  localparam logic [DW-1:0] MAXV = DW'(MODV - 1);
  localparam logic [DW:0]   MODW = (DW + 1)'(MODV);

  logic [DW-1:0] dig_reg  [NDIG];
  logic [DW-1:0] dig_next [NDIG];
  logic [DW-1:0] load_dig [NDIG];
  logic [DW-1:0] step_dig [NDIG];
  logic [NDIG-1:0] at_term;
  logic [NDIG-1:0] step_en;
  logic            ovf_reg;
  logic            sat_hold;

  // In saturate mode a terminal edge freezes every digit instead of wrapping.
  assign sat_hold = (SAT != 0) && tc;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      assign c[gi*DW +: DW] = dig_reg[gi];
      assign at_term[gi]    = up ? (dig_reg[gi] == MAXV) : (dig_reg[gi] == '0);
      // Prefix AND keeps the ripple chain free of self-referencing vector bits.
      assign cr[gi]         = s_s & (&at_term[gi:0]);

      if (gi == 0) begin : g_first
        assign step_en[gi] = 1'b1;
      end else begin : g_rest
        assign step_en[gi] = cr[gi-1];
      end

      assign load_dig[gi] = ({1'b0, d[gi*DW +: DW]} >= MODW) ? MAXV : d[gi*DW +: DW];
      assign step_dig[gi] = at_term[gi] ? (up ? '0 : MAXV)
                                        : (up ? dig_reg[gi] + 1'b1 : dig_reg[gi] - 1'b1);
      assign dig_next[gi] = l                                 ? load_dig[gi] :
                            (s_s && step_en[gi] && !sat_hold) ? step_dig[gi] :
                                                                dig_reg[gi];
    end
  endgenerate

  assign tc  = cr[NDIG-1];
  assign ovf = ovf_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NDIG; i++) dig_reg[i] <= '0;
      ovf_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NDIG; i++) dig_reg[i] <= dig_next[i];
      if (l)       ovf_reg <= 1'b0;
      else if (tc) ovf_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_cascade_nd.sv
// Bench for counter_cascade_nd: binary, BCD and saturating instances share one
// stimulus stream and are checked against a mixed-radix integer model.
module tb_counter_cascade_nd;

  localparam int NDIG = 2;
  localparam int DW   = 4;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic l = 1'b0, s_s = 1'b0, up = 1'b1;
  logic [NDIG*DW-1:0] d = '0;

  logic [7:0] c0, c1, c2;
  logic [1:0] cr0, cr1, cr2;
  logic tc0, tc1, tc2, ovf0, ovf1, ovf2;

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  counter_cascade_nd #(.NDIG(NDIG), .DW(DW), .MODV(16), .SAT(0)) u_bin (
    .clk(clk), .clr(clr), .l(l), .s_s(s_s), .up(up), .d(d),
    .c(c0), .cr(cr0), .tc(tc0), .ovf(ovf0));
  counter_cascade_nd #(.NDIG(NDIG), .DW(DW), .MODV(10), .SAT(0)) u_bcd (
    .clk(clk), .clr(clr), .l(l), .s_s(s_s), .up(up), .d(d),
    .c(c1), .cr(cr1), .tc(tc1), .ovf(ovf1));
  counter_cascade_nd #(.NDIG(NDIG), .DW(DW), .MODV(16), .SAT(1)) u_sat (
    .clk(clk), .clr(clr), .l(l), .s_s(s_s), .up(up), .d(d),
    .c(c2), .cr(cr2), .tc(tc2), .ovf(ovf2));

  always #5 clk = ~clk;

  // Model: whole counter is one integer in radix m; digits fall out by division.
  int modv_t [3] = '{16, 10, 16};
  bit sat_t  [3] = '{1'b0, 1'b0, 1'b1};
  int mval   [3] = '{0, 0, 0};
  bit movf   [3] = '{1'b0, 1'b0, 1'b0};

  function automatic int pw(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int load_val(input int m, input logic [7:0] dv);
    int v = 0;
    for (int i = 0; i < NDIG; i++) begin
      int dg;
      dg = int'(dv[i*DW +: DW]);
      if (dg >= m) dg = m - 1;
      v = v + dg * pw(m, i);
    end
    return v;
  endfunction

  function automatic logic [7:0] pack(input int m, input int v);
    logic [7:0] r = '0;
    for (int i = 0; i < NDIG; i++) r[i*DW +: DW] = 4'((v / pw(m, i)) % m);
    return r;
  endfunction

  function automatic logic [1:0] mcr(input int m, input int v, input logic ss, input logic u);
    logic [1:0] r = '0;
    for (int i = 0; i < NDIG; i++) begin
      int p;
      p = pw(m, i + 1);
      r[i] = ss && (u ? ((v % p) == p - 1) : ((v % p) == 0));
    end
    return r;
  endfunction

  always @(posedge clk or negedge clr) begin
    for (int k = 0; k < 3; k++) begin
      int m, top, nv;
      bit no;
      m = modv_t[k];
      top = pw(m, NDIG) - 1;
      nv = mval[k];
      no = movf[k];
      if (!clr) begin
        nv = 0; no = 1'b0;
      end else if (l) begin
        nv = load_val(m, d); no = 1'b0;
      end else if (s_s) begin
        if (up ? (nv == top) : (nv == 0)) begin
          no = 1'b1;
          if (!sat_t[k]) nv = up ? 0 : top;
        end else begin
          nv = up ? nv + 1 : nv - 1;
        end
      end
      mval[k] <= nv;
      movf[k] <= no;
    end
  end

  task automatic cmp_one(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL model inst%0d %s: got %h want %h at %0t", k, nm, act, exp, $time);
  endtask

  task automatic cmp_inst(input int k, input logic [7:0] cv, input logic [1:0] crv,
                          input logic tcv, input logic ovfv);
    logic [1:0] ecr;
    ecr = mcr(modv_t[k], mval[k], s_s, up);
    cmp_one("c",   k, cv,         pack(modv_t[k], mval[k]));
    cmp_one("cr",  k, {6'd0, crv}, {6'd0, ecr});
    cmp_one("tc",  k, {7'd0, tcv}, {7'd0, ecr[NDIG-1]});
    cmp_one("ovf", k, {7'd0, ovfv}, {7'd0, movf[k]});
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst(0, c0, cr0, tc0, ovf0);
      cmp_inst(1, c1, cr1, tc1, ovf1);
      cmp_inst(2, c2, cr2, tc2, ovf2);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [7:0] v);
    l = 1'b1; d = v;
    tick();
    l = 1'b0;
  endtask

  initial begin
    // 1: reset, load, count up
    tick(); tick();
    cmp_en = 1'b1;
    chk("reset_c", c0, 8'h00);
    chk("reset_ovf", {7'd0, ovf0}, 8'h00);
    clr = 1'b1;
    do_load(8'h0E);
    chk("load_0E", c0, 8'h0E);
    chk("load_ovf", {7'd0, ovf0}, 8'h00);
    chk("bcd_load_clamp", c1, 8'h09);
    s_s = 1'b1; up = 1'b1;
    tick(); chk("up_0F", c0, 8'h0F); chk("cr_at_F", {6'd0, cr0}, 8'h01);
    tick(); chk("up_10", c0, 8'h10); chk("cr_at_10", {6'd0, cr0}, 8'h00);
    tick(); chk("up_11", c0, 8'h11);
    $display("test1 done c=%h", c0);

    // 2: up wrap and sticky ovf
    do_load(8'hFE);
    chk("load_FE", c0, 8'hFE);
    tick(); chk("wrap_FF", c0, 8'hFF); chk("wrap_tc", {7'd0, tc0}, 8'h01);
    tick(); chk("wrap_00", c0, 8'h00); chk("wrap_ovf", {7'd0, ovf0}, 8'h01);
    repeat (5) tick();
    chk("ovf_sticky", {7'd0, ovf0}, 8'h01); chk("after5", c0, 8'h05);
    do_load(8'h00);
    chk("ovf_cleared", {7'd0, ovf0}, 8'h00);
    $display("test2 done c=%h ovf=%b", c0, ovf0);

    // 3: BCD
    do_load(8'h98);
    chk("bcd_98", c1, 8'h98);
    tick(); chk("bcd_99", c1, 8'h99); chk("bcd_tc", {7'd0, tc1}, 8'h01);
    tick(); chk("bcd_00", c1, 8'h00); chk("bcd_ovf", {7'd0, ovf1}, 8'h01);
    do_load(8'hAF);
    chk("bcd_clamp_AF", c1, 8'h99);
    up = 1'b0;
    do_load(8'h10);
    tick(); chk("bcd_dn_09", c1, 8'h09);
    tick(); chk("bcd_dn_08", c1, 8'h08);
    $display("test3 done c=%h", c1);

    // 4: saturating down
    do_load(8'h02);
    chk("sat_02", c2, 8'h02);
    tick(); chk("sat_01", c2, 8'h01);
    tick(); chk("sat_00", c2, 8'h00); chk("sat_tc", {7'd0, tc2}, 8'h01);
    tick(); chk("sat_hold", c2, 8'h00); chk("sat_ovf", {7'd0, ovf2}, 8'h01);
    tick(); chk("sat_hold2", c2, 8'h00);
    up = 1'b1;
    #1; chk("sat_tc_dirchg", {7'd0, tc2}, 8'h00);
    tick(); chk("sat_resume", c2, 8'h01);
    $display("test4 done c=%h", c2);

    // 5: load beats count, then hold
    do_load(8'hE0);
    chk("prio_E0", c0, 8'hE0);
    s_s = 1'b0;
    repeat (4) tick();
    chk("hold_c", c0, 8'hE0); chk("hold_cr", {6'd0, cr0}, 8'h00); chk("hold_tc", {7'd0, tc0}, 8'h00);
    $display("test5 done c=%h", c0);

    // 6: async reset mid-count
    s_s = 1'b1;
    do_load(8'h36);
    tick(); chk("cnt_37", c0, 8'h37);
    clr = 1'b0;
    #1; chk("async_c", c0, 8'h00); chk("async_ovf", {7'd0, ovf0}, 8'h00); chk("async_c_sat", c2, 8'h00);
    tick();
    clr = 1'b1;
    tick(); chk("resume_01", c0, 8'h01);
    $display("test6 done c=%h", c0);

    // Randomised traffic
    for (int it = 0; it < 3000; it++) begin
      if (!clr) clr = 1'b1;
      else if ($urandom_range(0, 99) < 2) clr = 1'b0;
      l   = ($urandom_range(0, 99) < 8);
      s_s = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 99) < 10) up = ~up;
      d   = 8'($urandom);
      tick();
    end
    clr = 1'b1;
    l = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
